int_dispatch_queue: RTL

//  4-wide in-order dispatch buffer between rename/RAT and the integer issue queue.
//  - Absorbs renamed uop groups (sources, destination, micro-opcode, immediate).
//  - Holds them while the issue queue stalls.
//  - Presents up to 4 oldest uops per cycle; the issue queue accepts any in-order prefix of them.

---
 rtl/int_dispatch_queue_pkg.sv | 39 +++
 rtl/int_dq_compact.sv | 24 ++
 rtl/int_dispatch_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/int_dispatch_queue_pkg.sv
// Shared types and helpers for the integer dispatch queue.
//   - Widths of the physical register tag, micro-opcode and immediate fields.
//   - dq_entry_t: one buffered uop
//     (src1/src2 able,rdy,tag + rd able,tag + opcode + imm able,value).
//   - wake_hit(): true when a tag matches any valid wakeup broadcast.
package int_dispatch_queue_pkg;

    localparam int unsigned PregW = 7;   // physical register tag width
    localparam int unsigned OpW   = 8;   // micro-opcode width
    localparam int unsigned ImmW  = 26;  // immediate width
    localparam int unsigned InW   = 4;   // rename width
    localparam int unsigned OutW  = 4;   // presentation width

    typedef struct packed {
        logic             src1_able;
        logic             src1_rdy;
        logic [PregW-1:0] src1_tag;
        logic             src2_able;
        logic             src2_rdy;
        logic [PregW-1:0] src2_tag;
        logic             rd_able;
        logic [PregW-1:0] rd_tag;
        logic [OpW-1:0]   opcode;
        logic             imm_able;
        logic [ImmW-1:0]  imm;
    } dq_entry_t;

    function automatic logic wake_hit(input logic [PregW-1:0]     tag,
                                      input logic [InW-1:0]       wake_valid,
                                      input logic [InW*PregW-1:0] wake_addr);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < int'(InW); j++) begin
            hit |= wake_valid[j] && (wake_addr[j*PregW +: PregW] == tag);
        end
        return hit;
    endfunction

endpackage

// File: rtl/int_dq_compact.sv
// Prefix popcount of the per-slot valid bits.
//   valid_i   : per-slot valid, slot 0 oldest
//   offset_o  : per-slot destination offset (number of valid slots before it)
//   count_o   : total number of valid slots
module int_dq_compact
    import int_dispatch_queue_pkg::*;
(
    input  logic [InW-1:0]       valid_i,
    output logic [InW-1:0][2:0]  offset_o,
    output logic [2:0]           count_o
);

    always_comb begin
        logic [2:0] acc;
        acc      = 3'd0;
        offset_o = '0;
        for (int k = 0; k < int'(InW); k++) begin
            offset_o[k] = acc;
            acc         = acc + {2'b00, valid_i[k]};
        end
        count_o = acc;
    end

endmodule

// File: rtl/int_dispatch_queue.sv
// 4-wide in-order dispatch buffer between rename and the integer issue queue.
// Ports:
//   clk_i, rest_i (sync, active-high), dq_stop_i (hold), dq_flash_i (discard all)
//   in_*_i    : renamed uop group, slot k at [k*W +: W]; in_ready_o accepts it
//   wake_*_i  : wakeup broadcasts (used only with INT_DQ_WAKEUP_EN)
//   out_*_o   : up to 4 oldest entries, slot 0 = head; out_valid_o is a thermometer
//   out_accept_num_i : entries taken by the issue queue; dq_count_o : occupancy
// Configuration: define INT_DQ_WAKEUP_EN to let wakeups set source ready bits of
// stored and incoming entries.
module int_dispatch_queue
    import int_dispatch_queue_pkg::*;
#(
    parameter int unsigned Depth = 16,
    localparam int unsigned IdxW = $clog2(Depth),
    localparam int unsigned PtrW = IdxW + 1
) (
    input  logic                  clk_i,
    input  logic                  rest_i,
    input  logic                  dq_stop_i,
    input  logic                  dq_flash_i,
    input  logic [InW-1:0]        in_valid_i,
    input  logic [InW-1:0]        in_src1_able_i,
    input  logic [InW-1:0]        in_src2_able_i,
    input  logic [InW-1:0]        in_rd_able_i,
    input  logic [InW-1:0]        in_imm_able_i,
    input  logic [InW*PregW-1:0]  in_src1_addr_i,
    input  logic [InW*PregW-1:0]  in_src2_addr_i,
    input  logic [InW*PregW-1:0]  in_rd_addr_i,
    input  logic [InW-1:0]        in_src1_rdy_i,
    input  logic [InW-1:0]        in_src2_rdy_i,
    input  logic [InW*OpW-1:0]    in_mic_opcode_i,
    input  logic [InW*ImmW-1:0]   in_imm_date_i,
    output logic                  in_ready_o,
    input  logic [InW-1:0]        wake_valid_i,
    input  logic [InW*PregW-1:0]  wake_addr_i,
    output logic [OutW-1:0]       out_valid_o,
    output logic [OutW-1:0]       out_src1_able_o,
    output logic [OutW-1:0]       out_src2_able_o,
    output logic [OutW-1:0]       out_rd_able_o,
    output logic [OutW-1:0]       out_imm_able_o,
    output logic [OutW*PregW-1:0] out_src1_addr_o,
    output logic [OutW*PregW-1:0] out_src2_addr_o,
    output logic [OutW*PregW-1:0] out_rd_addr_o,
    output logic [OutW-1:0]       out_src1_rdy_o,
    output logic [OutW-1:0]       out_src2_rdy_o,
    output logic [OutW*OpW-1:0]   out_mic_opcode_o,
    output logic [OutW*ImmW-1:0]  out_imm_date_o,
    input  logic [2:0]            out_accept_num_i,
    output logic [PtrW-1:0]       dq_count_o
);

    dq_entry_t             mem_q [Depth];
    dq_entry_t             mem_d [Depth];
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [PtrW-1:0]       count;
    logic [InW-1:0][2:0]   offset;
    logic [2:0]            enq_num, out_cnt, deq_num;
    logic                  fire;
    dq_entry_t [InW-1:0]   in_entry;

    int_dq_compact u_compact (
        .valid_i  (in_valid_i),
        .offset_o (offset),
        .count_o  (enq_num)
    );

    // Wrap bit makes tail - head the exact occupancy, including full.
    assign count      = tail_q - head_q;
    assign dq_count_o = count;
    assign in_ready_o = ((PtrW'(Depth) - count) >= PtrW'(InW)) && !dq_stop_i && !dq_flash_i;
    assign fire       = in_ready_o && (|in_valid_i);
    assign out_cnt    = (count >= PtrW'(OutW)) ? 3'(OutW) : count[2:0];

    // Over-accept is illegal upstream; clamp anyway so pointers never overtake.
    always_comb begin
        deq_num = (out_accept_num_i > out_cnt) ? out_cnt : out_accept_num_i;
        if (dq_stop_i) deq_num = 3'd0;
    end

    always_comb begin
        in_entry = '0;
        for (int k = 0; k < int'(InW); k++) begin
            in_entry[k].src1_able = in_src1_able_i[k];
            in_entry[k].src1_rdy  = in_src1_rdy_i[k];
            in_entry[k].src1_tag  = in_src1_addr_i[k*PregW +: PregW];
            in_entry[k].src2_able = in_src2_able_i[k];
            in_entry[k].src2_rdy  = in_src2_rdy_i[k];
            in_entry[k].src2_tag  = in_src2_addr_i[k*PregW +: PregW];
            in_entry[k].rd_able   = in_rd_able_i[k];
            in_entry[k].rd_tag    = in_rd_addr_i[k*PregW +: PregW];
            in_entry[k].opcode    = in_mic_opcode_i[k*OpW +: OpW];
            in_entry[k].imm_able  = in_imm_able_i[k];
            in_entry[k].imm       = in_imm_date_i[k*ImmW +: ImmW];
`ifdef INT_DQ_WAKEUP_EN
            if (in_entry[k].src1_able &&
                wake_hit(in_entry[k].src1_tag, wake_valid_i, wake_addr_i)) begin
                in_entry[k].src1_rdy = 1'b1;
            end
            if (in_entry[k].src2_able &&
                wake_hit(in_entry[k].src2_tag, wake_valid_i, wake_addr_i)) begin
                in_entry[k].src2_rdy = 1'b1;
            end
`endif
        end
    end

`ifndef INT_DQ_WAKEUP_EN
    logic unused_wake;
    assign unused_wake = ^{wake_valid_i, wake_addr_i};
`endif

    always_comb begin
        mem_d = mem_q;
`ifdef INT_DQ_WAKEUP_EN
        // Non-live entries may also be woken; they are overwritten before use.
        for (int i = 0; i < int'(Depth); i++) begin
            if (mem_d[i].src1_able && wake_hit(mem_d[i].src1_tag, wake_valid_i, wake_addr_i)) begin
                mem_d[i].src1_rdy = 1'b1;
            end
            if (mem_d[i].src2_able && wake_hit(mem_d[i].src2_tag, wake_valid_i, wake_addr_i)) begin
                mem_d[i].src2_rdy = 1'b1;
            end
        end
`endif
        for (int k = 0; k < int'(InW); k++) begin
            if (fire && in_valid_i[k]) begin
                mem_d[tail_q[IdxW-1:0] + IdxW'(offset[k])] = in_entry[k];
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (dq_flash_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PtrW'(deq_num);
            if (fire) tail_d = tail_q + PtrW'(enq_num);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rest_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        dq_entry_t e;
        e = '0;
        for (int k = 0; k < int'(OutW); k++) begin
            e = mem_q[head_q[IdxW-1:0] + IdxW'(k)];
            out_valid_o[k]                   = count > PtrW'(k);
            out_src1_able_o[k]               = e.src1_able;
            out_src1_rdy_o[k]                = e.src1_rdy;
            out_src1_addr_o[k*PregW +: PregW] = e.src1_tag;
            out_src2_able_o[k]               = e.src2_able;
            out_src2_rdy_o[k]                = e.src2_rdy;
            out_src2_addr_o[k*PregW +: PregW] = e.src2_tag;
            out_rd_able_o[k]                 = e.rd_able;
            out_rd_addr_o[k*PregW +: PregW]  = e.rd_tag;
            out_mic_opcode_o[k*OpW +: OpW]   = e.opcode;
            out_imm_able_o[k]                = e.imm_able;
            out_imm_date_o[k*ImmW +: ImmW]   = e.imm;
        end
    end

    ap_accept_legal: assert property (@(posedge clk_i) disable iff (rest_i)
        (out_accept_num_i <= out_cnt) && !(dq_stop_i && (out_accept_num_i != 3'd0)));

endmodule
